// File: rtl/int_to_float.sv
// int_to_float: 32-bit signed integer to IEEE-754 single, round-nearest-even, serial normalise.
// Optional output_inexact port enabled by defining I2F_INEXACT_EN.
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
`ifdef I2F_INEXACT_EN
  ,
  output logic        output_inexact
`endif
);
  typedef enum logic [2:0] {GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z} state_t;
  state_t      state_q, state_d;
  logic [31:0] value_q, value_d;
  logic [31:0] z_q, z_d;
  logic [22:0] mant_q, mant_d;
  logic [5:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        stb_q, stb_d;
  logic        round_up;
`ifdef I2F_INEXACT_EN
  logic        inx_q, inx_d;
  assign output_inexact = inx_q;
`endif
  assign input_a_ack  = (state_q == GET_A) && rst;
  assign output_z     = z_q;
  assign output_z_stb = stb_q;
  assign round_up     = value_q[7] && (value_q[6] || |value_q[5:0] || value_q[8]);
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    z_d     = z_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    stb_d   = stb_q;
`ifdef I2F_INEXACT_EN
    inx_d   = inx_q;
`endif
    case (state_q)
      GET_A: if (input_a_stb && input_a_ack) begin
        value_d = input_a;
        state_d = CONVERT;
      end
      CONVERT: if (value_q == 32'd0) begin
        z_d     = 32'd0;
        stb_d   = 1'b1;
        state_d = PUT_Z;
`ifdef I2F_INEXACT_EN
        inx_d   = 1'b0;
`endif
      end else begin
        sign_d  = value_q[31];
        value_d = value_q[31] ? -value_q : value_q;
        exp_d   = 6'd31;
        state_d = NORMALISE;
      end
      NORMALISE: if (!value_q[31]) begin
        value_d = value_q << 1;
        exp_d   = exp_q - 6'd1;
      end else begin
        state_d = ROUND;
      end
      ROUND: begin
        // the hidden bit is always set here, so a wrap of the fraction is the carry into the exponent
        mant_d  = value_q[30:8] + 23'(round_up);
        exp_d   = exp_q + 6'(round_up && &value_q[30:8]);
        state_d = PACK;
      end
      PACK: begin
        z_d     = {sign_q, 8'(exp_q) + 8'd127, mant_q};
        stb_d   = 1'b1;
        state_d = PUT_Z;
`ifdef I2F_INEXACT_EN
        inx_d   = |value_q[7:0];
`endif
      end
      PUT_Z: if (output_z_ack) begin
        stb_d   = 1'b0;
        state_d = GET_A;
      end
      default: state_d = GET_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= GET_A;
      value_q <= '0;
      z_q     <= '0;
      mant_q  <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      stb_q   <= 1'b0;
`ifdef I2F_INEXACT_EN
      inx_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      z_q     <= z_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      stb_q   <= stb_d;
`ifdef I2F_INEXACT_EN
      inx_q   <= inx_d;
`endif
    end
  end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: directed and random conversions checked against an arithmetic reference model.
module tb_int_to_float;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;
  logic        inexact;
  int          passes = 0;
  int          total = 0;
  int_to_float dut (
    .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb),
    .input_a_ack(input_a_ack), .output_z(output_z), .output_z_stb(output_z_stb),
    .output_z_ack(output_z_ack)
`ifdef I2F_INEXACT_EN
    , .output_inexact(inexact)
`endif
  );
`ifndef I2F_INEXACT_EN
  assign inexact = 1'b0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic void model(input logic [31:0] a, output logic [31:0] z, output int lat, output logic inx);
    longint m, q, rem, half;
    int e;
    if (a == 32'd0) begin
      z = 32'd0; lat = 1; inx = 1'b0;
      return;
    end
    m = a[31] ? (64'h1_0000_0000 - longint'(a)) : longint'(a);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    lat = 4 + 31 - e;
    rem = 0;
    if (e <= 23) q = m << (23 - e);
    else begin
      q = m >> (e - 23);
      rem = m - (q << (e - 23));
      half = longint'(1) << (e - 24);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (longint'(1) << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    inx = rem != 0;
    z = {a[31], 8'(e + 127), q[22:0]};
  endfunction
  task automatic conv(input logic [31:0] a, input int hold);
    logic [31:0] ez;
    int elat, cyc;
    logic einx;
    model(a, ez, elat, einx);
    cyc = 0;
    while (!input_a_ack && cyc < 50) begin tick(); cyc++; end
    chk("ready", 32'(input_a_ack), 32'd1);
    input_a = a;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    input_a = $urandom;
    cyc = 0;
    while (!output_z_stb && cyc < 50) begin tick(); cyc++; end
    chk($sformatf("lat %h", a), 32'(cyc), 32'(elat));
    chk($sformatf("z %h", a), output_z, ez);
`ifdef I2F_INEXACT_EN
    chk($sformatf("inexact %h", a), 32'(inexact), 32'(einx));
`endif
    for (int i = 0; i < hold; i++) begin
      input_a_stb = 1'b1;
      tick();
      chk("hold stb", 32'(output_z_stb), 32'd1);
      chk("hold z", output_z, ez);
      chk("hold ack_in", 32'(input_a_ack), 32'd0);
    end
    input_a_stb = 1'b0;
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("stb cleared", 32'(output_z_stb), 32'd0);
    chk("ack_in after", 32'(input_a_ack), 32'd1);
  endtask
  initial begin
    logic [31:0] dir [8];
    dir = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000,
            32'h00FFFFFF, 32'h01000001, 32'h01000003, 32'h7FFFFFC0};
    tick();
    tick();
    chk("rst stb", 32'(output_z_stb), 32'd0);
    chk("rst z", output_z, 32'd0);
    chk("rst ack_in", 32'(input_a_ack), 32'd0);
    rst = 1'b1;
    tick();
    chk("ack_in post rst", 32'(input_a_ack), 32'd1);
    conv(32'h00000002, 0);
    conv(32'hFFFFFFF9, 0);
    conv(32'h00000000, 0);
    conv(32'h80000000, 0);
    conv(32'h7FFFFFFF, 10);
    foreach (dir[i]) conv(dir[i], 1);
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    chk("spurious ack stb", 32'(output_z_stb), 32'd0);
    chk("spurious ack ready", 32'(input_a_ack), 32'd1);
    input_a = 32'h00000002;
    input_a_stb = 1'b1;
    tick();
    input_a_stb = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    tick();
    chk("mid rst ack_in", 32'(input_a_ack), 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (output_z_stb) break;
      tick();
    end
    chk("no result after rst", 32'(output_z_stb), 32'd0);
    conv(32'h00000002, 0);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom;
      r = r >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      conv(r, $urandom_range(0, 2));
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
